decompressor: RTL and testbench

DECOMPRESSOR -- requirements
Module: decompressor

---
 rtl/decompressor.sv | 184 ++++++++++++++++++
 tb/tb_decompressor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompressor.sv
// Purpose : expands one base+delta compressed 256-bit line into a full line.
// Latency : zero/raw/illegal -> out_valid on accepting edge; B8/B4/B2 -> 3/7/15 edges later.
// Backpr. : single-line buffer; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports: clk, rst (async active-low); in_valid/in_ready + i_data/encoding on the input
// side; out_valid/out_ready + o_data/err on the output side.
// Parameter ILLEGAL_AS_RAW: when 1 the illegal code 0001 is passed through as raw.
module decompressor #(
    parameter bit ILLEGAL_AS_RAW = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] i_data,
    input  logic [3:0]   encoding,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] o_data,
    output logic         err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // bsel: 0 = 2-byte base, 1 = 4-byte, 2 = 8-byte
    // dsel: 0 = 1-byte delta, 1 = 2-byte, 2 = 4-byte
    typedef struct packed {
        logic       comp;
        logic [1:0] bsel;
        logic [1:0] dsel;
    } fmt_t;

    function automatic fmt_t decode_fmt(input logic [3:0] enc);
        fmt_t f;
        f = '0;
        case (enc)
            4'b0010: f = '{comp: 1'b1, bsel: 2'd2, dsel: 2'd0}; // B8D1
            4'b0100: f = '{comp: 1'b1, bsel: 2'd2, dsel: 2'd1}; // B8D2
            4'b0011: f = '{comp: 1'b1, bsel: 2'd2, dsel: 2'd2}; // B8D4
            4'b0110: f = '{comp: 1'b1, bsel: 2'd1, dsel: 2'd0}; // B4D1
            4'b0101: f = '{comp: 1'b1, bsel: 2'd1, dsel: 2'd1}; // B4D2
            4'b0111: f = '{comp: 1'b1, bsel: 2'd0, dsel: 2'd0}; // B2D1
            default: f = '0;
        endcase
        return f;
    endfunction

    function automatic logic [63:0] width_mask(input logic [1:0] bsel);
        logic [63:0] m;
        case (bsel)
            2'd2:    m = 64'hFFFF_FFFF_FFFF_FFFF;
            2'd1:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'h0000_0000_0000_FFFF;
        endcase
        return m;
    endfunction

    logic [1:0]   state;
    logic [3:0]   idx;
    logic [255:0] lat_data;
    logic [3:0]   lat_enc;

    fmt_t         in_fmt;
    fmt_t         lat_fmt;
    logic [63:0]  b_mask;
    logic [63:0]  base;
    logic [63:0]  delta;
    logic [63:0]  elem;
    logic [31:0]  slot_win;
    logic [8:0]   base_bits;
    logic [8:0]   slot_off;
    logic [7:0]   elem_off;
    logic [3:0]   last_idx;
    logic [255:0] line_next;

    assign in_fmt    = decode_fmt(encoding);
    assign lat_fmt   = decode_fmt(lat_enc);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Element idx of the latched line: base + sign-extended slot idx, truncated to
    // the element width, then merged into its lane without touching neighbours.
    always_comb begin
        b_mask    = width_mask(lat_fmt.bsel);
        elem_off  = '0;
        last_idx  = '0;
        base_bits = '0;
        case (lat_fmt.bsel)
            2'd2: begin
                elem_off  = {idx[1:0], 6'd0};
                last_idx  = 4'd3;
                base_bits = 9'd64;
            end
            2'd1: begin
                elem_off  = {idx[2:0], 5'd0};
                last_idx  = 4'd7;
                base_bits = 9'd32;
            end
            default: begin
                elem_off  = {idx, 4'd0};
                last_idx  = 4'd15;
                base_bits = 9'd16;
            end
        endcase

        case (lat_fmt.dsel)
            2'd0:    slot_off = base_bits + {2'b00, idx, 3'd0};
            2'd1:    slot_off = base_bits + {1'b0, idx, 4'd0};
            default: slot_off = base_bits + {idx, 5'd0};
        endcase

        slot_win = 32'(lat_data >> slot_off);

        case (lat_fmt.dsel)
            2'd0:    delta = {{56{slot_win[7]}},  slot_win[7:0]};
            2'd1:    delta = {{48{slot_win[15]}}, slot_win[15:0]};
            default: delta = {{32{slot_win[31]}}, slot_win[31:0]};
        endcase

        base      = lat_data[63:0] & b_mask;
        elem      = (base + delta) & b_mask;
        line_next = (o_data & ~({192'd0, b_mask} << elem_off))
                  | ({192'd0, elem} << elem_off);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            o_data   <= '0;
            err      <= 1'b0;
            lat_data <= '0;
            lat_enc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        lat_data <= i_data;
                        lat_enc  <= encoding;
                        err      <= 1'b0;
                        if (in_fmt.comp) begin
                            // element 0 is the base itself; the rest of the line starts clear
                            o_data <= {192'd0, i_data[63:0] & width_mask(in_fmt.bsel)};
                            idx    <= 4'd1;
                            state  <= EXPAND;
                        end else begin
                            idx   <= '0;
                            state <= DONE;
                            if (encoding[3]) begin
                                o_data <= i_data;
                            end else if (encoding == 4'b0001) begin
                                if (ILLEGAL_AS_RAW) begin
                                    o_data <= i_data;
                                end else begin
                                    o_data <= '0;
                                    err    <= 1'b1;
                                end
                            end else begin
                                o_data <= '0;
                            end
                        end
                    end
                end
                EXPAND: begin
                    o_data <= line_next;
                    idx    <= idx + 4'd1;
                    if (idx == last_idx) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decompressor.sv
// Purpose : self-checking bench for decompressor against a whole-line reference model.
// Latency : measures edges from accept to out_valid for every line.
// Backpr. : exercises held out_ready, blocked second line and mid-operation reset.
module tb_decompressor;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] i_data;
    logic [3:0]   encoding;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] o_data;
    logic         err;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [255:0] o_data_r;
    logic         err_r;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decompressor #(.ILLEGAL_AS_RAW(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i_data(i_data), .encoding(encoding), .out_valid(out_valid),
        .out_ready(out_ready), .o_data(o_data), .err(err)
    );

    decompressor #(.ILLEGAL_AS_RAW(1'b1)) dut_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .i_data(i_data), .encoding(encoding), .out_valid(out_valid_r),
        .out_ready(out_ready), .o_data(o_data_r), .err(err_r)
    );

    // Whole-line reference: expected line, error flag and accept-to-valid latency.
    function automatic void ref_line(input logic [3:0] enc, input logic [255:0] din,
                                     input bit iar, output logic [255:0] exp_line,
                                     output logic exp_err, output int exp_lat);
        int b, d, n;
        logic [63:0] bmask, dmask, base, s, e;
        logic [255:0] tmp;
        b = 0; d = 0;
        exp_line = '0; exp_err = 1'b0; exp_lat = 0;
        case (enc)
            4'b0010: begin b = 8; d = 1; end
            4'b0100: begin b = 8; d = 2; end
            4'b0011: begin b = 8; d = 4; end
            4'b0110: begin b = 4; d = 1; end
            4'b0101: begin b = 4; d = 2; end
            4'b0111: begin b = 2; d = 1; end
            default: ;
        endcase
        if (enc[3]) begin
            exp_line = din;
        end else if (enc == 4'b0001) begin
            if (iar) exp_line = din;
            else     exp_err  = 1'b1;
        end else if (b != 0) begin
            n       = 32 / b;
            exp_lat = n - 1;
            bmask   = (b == 8) ? {64{1'b1}} : ((64'd1 << (8 * b)) - 64'd1);
            dmask   = (64'd1 << (8 * d)) - 64'd1;
            base    = din[63:0] & bmask;
            exp_line = {192'd0, base};
            for (int k = 1; k < n; k++) begin
                tmp = din >> (8 * b + 8 * d * k);
                s   = tmp[63:0] & dmask;
                if (s[8 * d - 1]) s = s | ~dmask;
                e   = (base + s) & bmask;
                exp_line = exp_line | ({192'd0, e} << (8 * b * k));
            end
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one line for a single edge, then scramble the inputs.
    task automatic present(input logic [3:0] enc, input logic [255:0] d);
        in_valid = 1'b1;
        encoding = enc;
        i_data   = d;
        step();
        in_valid = 1'b0;
        encoding = 4'($urandom);
        i_data   = rand256();
    endtask

    // Count edges until out_valid while toggling junk on the inputs; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            encoding = 4'($urandom);
            i_data   = rand256();
            step();
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) lat = -1;
    endtask

    task automatic release_line();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; i_data = '0; encoding = '0;
        #2;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_o_data got %h want 0", o_data); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_b8d1();
        int lat;
        logic [255:0] want;
        want = {64'h1010, 64'h0FFE, 64'h1005, 64'h1000};
        present(4'b0010, {160'h0, 8'h10, 8'hFE, 8'h05, 8'h00, 64'h1000});
        wait_out(lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL b8d1_latency got %0d want 3", lat); end
        n_cmp++; if (o_data !== want) begin n_fail++; $display("FAIL b8d1_data got %h want %h", o_data, want); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL b8d1_err got %b want 0", err); end
        release_line();
    endtask

    task automatic test_b2d1_wrap();
        int lat;
        logic [255:0] want;
        want = {240'h0, 16'hFFFF};
        present(4'b0111, {112'h0, {16{8'h01}}, 16'hFFFF});
        wait_out(lat);
        n_cmp++; if (lat !== 15) begin n_fail++; $display("FAIL b2d1_latency got %0d want 15", lat); end
        n_cmp++; if (o_data !== want) begin n_fail++; $display("FAIL b2d1_wrap got %h want %h", o_data, want); end
        release_line();
    endtask

    task automatic test_zero_raw();
        int lat;
        logic [255:0] d;
        present(4'b0000, rand256());
        wait_out(lat);
        n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL zero_latency got %0d want 0", lat); end
        n_cmp++; if (o_data !== '0) begin n_fail++; $display("FAIL zero_data got %h want 0", o_data); end
        release_line();
        d = {32{8'hA5}};
        present(4'b1000, d);
        wait_out(lat);
        n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL raw_latency got %0d want 0", lat); end
        n_cmp++; if (o_data !== d) begin n_fail++; $display("FAIL raw_data got %h want %h", o_data, d); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL raw_err got %b want 0", err); end
        release_line();
    endtask

    task automatic test_illegal();
        int lat;
        logic [255:0] d;
        d = rand256();
        present(4'b0001, d);
        wait_out(lat);
        n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL illegal_latency got %0d want 0", lat); end
        n_cmp++; if (o_data !== '0) begin n_fail++; $display("FAIL illegal_data got %h want 0", o_data); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", err); end
        n_cmp++; if (o_data_r !== d) begin n_fail++; $display("FAIL illegal_raw_data got %h want %h", o_data_r, d); end
        n_cmp++; if (err_r !== 1'b0) begin n_fail++; $display("FAIL illegal_raw_err got %b want 0", err_r); end
        release_line();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear got %b want 0", err); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [255:0] d1, d2, hold, want;
        logic werr;
        int wlat;
        d1 = rand256();
        d2 = rand256();
        ref_line(4'b0011, d1, 1'b0, want, werr, wlat);
        present(4'b0011, d1);
        wait_out(lat);
        n_cmp++; if (lat !== wlat) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, wlat); end
        n_cmp++; if (o_data !== want) begin n_fail++; $display("FAIL bp_data got %h want %h", o_data, want); end
        hold = want;
        in_valid = 1'b1; encoding = 4'b1000; i_data = d2;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++; if (o_data !== hold) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %h want %h", c, o_data, hold); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc %0d got %b want 1", c, out_valid); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_pop got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || o_data !== d2) begin n_fail++; $display("FAIL bp_second got vld=%b %h want vld=1 %h", out_valid, o_data, d2); end
        release_line();
    endtask

    task automatic test_reset_mid();
        int lat, wlat;
        logic [255:0] d, want;
        logic werr;
        present(4'b0001, rand256());
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_done got err=%b vld=%b want 0 0", err, out_valid); end
        step();
        rst = 1'b1;
        present(4'b0101, rand256());
        step();
        step();
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (o_data !== '0) begin n_fail++; $display("FAIL rst_mid_data got %h want 0", o_data); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        step();
        rst = 1'b1;
        d = rand256();
        ref_line(4'b0101, d, 1'b0, want, werr, wlat);
        present(4'b0101, d);
        wait_out(lat);
        n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL rst_fresh_latency got %0d want 7", lat); end
        n_cmp++; if (o_data !== want) begin n_fail++; $display("FAIL rst_fresh_data got %h want %h", o_data, want); end
        release_line();
    endtask

    task automatic test_back_to_back();
        int lat, wlat, wlat_r;
        logic [255:0] d, want, want_r;
        logic werr, werr_r;
        logic [3:0] enc;
        for (int t = 0; t < 60; t++) begin
            enc = 4'($urandom_range(0, 15));
            d   = rand256();
            ref_line(enc, d, 1'b0, want, werr, wlat);
            ref_line(enc, d, 1'b1, want_r, werr_r, wlat_r);
            present(enc, d);
            wait_out(lat);
            n_cmp++; if (lat !== wlat) begin n_fail++; $display("FAIL rnd_latency enc=%b got %0d want %0d", enc, lat, wlat); end
            n_cmp++; if (o_data !== want) begin n_fail++; $display("FAIL rnd_data enc=%b got %h want %h", enc, o_data, want); end
            n_cmp++; if (err !== werr) begin n_fail++; $display("FAIL rnd_err enc=%b got %b want %b", enc, err, werr); end
            n_cmp++; if (o_data_r !== want_r || err_r !== werr_r) begin n_fail++; $display("FAIL rnd_raw enc=%b got %h/%b want %h/%b", enc, o_data_r, err_r, want_r, werr_r); end
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) step();
            release_line();
            n_cmp++; if (out_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rnd_pop got vld=%b err=%b want 0 0", out_valid, err); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_b8d1();
        test_b2d1_wrap();
        test_zero_raw();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
